multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/add ops plus iterative shift-add MUL.
// Define ALU_DIVIDER_EN to make DIV an iterative restoring divider (else DIV is A>>1).
module multicycle_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Operation,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] BusC,
  output logic             Busy,
  output logic             Done,
  output logic             FlagZ,
  output logic             FlagC,
  output logic             FlagV,
  output logic             FlagDZ
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned DW   = 2 * WIDTH;

  localparam logic [2:0] OpClr  = 3'b000;
  localparam logic [2:0] OpPass = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpShl  = 3'b011;
  localparam logic [2:0] OpAdd  = 3'b100;
  localparam logic [2:0] OpSub  = 3'b101;
  localparam logic [2:0] OpMul  = 3'b110;
  localparam logic [2:0] OpDiv  = 3'b111;

  typedef enum logic [0:0] {IDLE, ITER} stateT;

  stateT            state, nextState;
  logic [CntW-1:0]  cnt, nextCnt;
  logic [DW-1:0]    prod, nextProd;   // MUL: {hi, lo/multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0] opnd, nextOpnd;   // MUL: multiplicand; DIV: divisor
  logic [WIDTH-1:0] nextBusC;
  logic             nextBusy, nextDone, nextZ, nextC, nextV;
  logic [WIDTH:0]   addSum, mulSum;
  logic [DW-1:0]    mulStep, iterStep;
  logic             isIterOp, lastIter;

`ifdef ALU_DIVIDER_EN
  logic             isDiv, nextIsDiv, nextDz;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divDiff;
  logic             divFits;
  logic [DW-1:0]    divStep;
`endif

  // One iteration of each iterative datapath
  always_comb begin
    addSum  = {1'b0, BusA} + {1'b0, BusB};
    mulSum  = {1'b0, prod[DW-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    mulStep = {mulSum, prod[WIDTH-1:1]};
`ifdef ALU_DIVIDER_EN
    divShift = {prod[DW-1:WIDTH], prod[WIDTH-1]};
    divFits  = divShift >= {1'b0, opnd};
    divDiff  = divShift[WIDTH-1:0] - opnd;
    divStep  = {(divFits ? divDiff : divShift[WIDTH-1:0]), prod[WIDTH-2:0], divFits};
    iterStep = isDiv ? divStep : mulStep;
    isIterOp = (Operation == OpMul) || (Operation == OpDiv);
`else
    iterStep = mulStep;
    isIterOp = (Operation == OpMul);
`endif
    lastIter = (cnt == CntW'(WIDTH - 1));
  end

  // Next-state and registered-output logic
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    nextProd  = prod;
    nextOpnd  = opnd;
    nextBusC  = BusC;
    nextBusy  = Busy;
    nextDone  = 1'b0;
    nextZ     = FlagZ;
    nextC     = FlagC;
    nextV     = FlagV;
`ifdef ALU_DIVIDER_EN
    nextIsDiv = isDiv;
    nextDz    = FlagDZ;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
          nextCnt = '0;
          if (isIterOp) begin
            nextState = ITER;
            nextBusy  = 1'b1;
            nextProd  = {WIDTH'(0), BusB};
            nextOpnd  = BusA;
`ifdef ALU_DIVIDER_EN
            nextIsDiv = (Operation == OpDiv);
            if (Operation == OpDiv) begin
              nextProd = {WIDTH'(0), BusA};
              nextOpnd = BusB;
            end
`endif
          end else begin
            nextDone = 1'b1;
            nextBusC = '0;
            nextZ    = 1'b0;
            nextC    = 1'b0;
            nextV    = 1'b0;
`ifdef ALU_DIVIDER_EN
            nextDz   = 1'b0;
`endif
            case (Operation)
              OpAdd: begin
                nextBusC = addSum[WIDTH-1:0];
                nextC    = addSum[WIDTH];
              end
              OpSub: begin
                nextBusC = BusA - BusB;
                nextC    = BusA < BusB;
                nextZ    = (BusA == '0);
              end
              OpPass: begin
                nextBusC = BusB;
                nextZ    = (BusA == '0);
              end
              OpAnd:   nextBusC = BusA & BusB;
              OpShl:   nextBusC = BusA << 2;
`ifndef ALU_DIVIDER_EN
              OpDiv:   nextBusC = BusA >> 1;
`endif
              default: nextBusC = '0;
            endcase
          end
        end
      end
      ITER: begin
        nextProd = iterStep;
        nextCnt  = cnt + CntW'(1);
        if (lastIter) begin
          nextState = IDLE;
          nextBusy  = 1'b0;
          nextDone  = 1'b1;
          nextBusC  = iterStep[WIDTH-1:0];
          nextZ     = 1'b0;
          nextC     = 1'b0;
`ifdef ALU_DIVIDER_EN
          nextV     = !isDiv && (mulStep[DW-1:WIDTH] != '0);
          nextDz    = isDiv && (opnd == '0);
`else
          nextV     = (mulStep[DW-1:WIDTH] != '0);
`endif
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State and output registers; synchronous reset has priority over Start
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      opnd  <= '0;
      BusC  <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      FlagZ <= 1'b0;
      FlagC <= 1'b0;
      FlagV <= 1'b0;
`ifdef ALU_DIVIDER_EN
      isDiv  <= 1'b0;
      FlagDZ <= 1'b0;
`endif
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      prod  <= nextProd;
      opnd  <= nextOpnd;
      BusC  <= nextBusC;
      Busy  <= nextBusy;
      Done  <= nextDone;
      FlagZ <= nextZ;
      FlagC <= nextC;
      FlagV <= nextV;
`ifdef ALU_DIVIDER_EN
      isDiv  <= nextIsDiv;
      FlagDZ <= nextDz;
`endif
    end
  end

`ifndef ALU_DIVIDER_EN
  assign FlagDZ = 1'b0;
`endif

endmodule
